rename_alloc: RTL and testbench
===============================

Name: rename_alloc

Overview:
- Single-issue register-rename stage between decode and dispatch.
- Maps architectural sources and destination to physical registers using a speculative RAT.
- Pops new destination tags from the physical free-list FIFO and pushes retired or squashed tags back into it.
- Holds a committed (architectural) RAT for flush recovery. p0 is the hard-wired zero register: never allocated, never released.

Parameters:
- ARCH_REG_NUM, 32, number of architectural registers
- ARCH_REG_WIDTH, 5, architectural index width
- PHY_REG_WIDTH, 6, physical tag width (p0..p32 used)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage can accept
- in_rs1, in_rs2  in  ARCH_REG_WIDTH  source arch regs
- in_rd  in  ARCH_REG_WIDTH  dest arch reg
- in_rd_wen  in  1  instruction writes rd
- out_valid  out  1  renamed instruction valid
- out_ready  in  1  downstream accepts
- out_prs1, out_prs2  out  PHY_REG_WIDTH  source phys tags
- out_prd  out  PHY_REG_WIDTH  new dest tag (0 if none)
- out_old_prd  out  PHY_REG_WIDTH  previous mapping of rd (0 if none)
- out_rd_wen  out  1  effective dest write
- fl_rd_en  out  1  pop free list
- fl_rdata  in  PHY_REG_WIDTH  free-list head
- fl_empty  in  1  free list empty
- fl_wr_en  out  1  push free list
- fl_wdata  out  PHY_REG_WIDTH  tag released
- fl_full  in  1  free list full
- cm_valid  in  1  commit of one instruction
- cm_rd, cm_prd, cm_old_prd, cm_rd_wen  in  -  committed mapping
- sq_valid  in  1  squashed tag release
- sq_prd  in  PHY_REG_WIDTH  squashed tag
- sq_ready  out  1  squash release accepted
- flush  in  1  one-cycle recovery pulse
- err_overflow  out  1  sticky: release attempted while fl_full

Behaviour:
- Reset: both RATs all entries 0; out_valid=0; out_* payload 0; err_overflow=0. Combinational outputs reflect reset state.
- need_dest = in_rd_wen & (in_rd != 0).
- in_ready = !flush & (!out_valid | out_ready) & (!need_dest | !fl_empty).
- accept = in_valid & in_ready; fl_rd_en = accept & need_dest.
- fl_rdata is consumed in the same cycle (FIFO has combinational read).
- On accept, the output register loads on the next edge:
  - prs1/prs2 = spec_rat[rs]; rs=0 yields 0.
  - prd = fl_rdata if need_dest, else 0.
  - old_prd = spec_rat[in_rd] if need_dest, else 0.
  - out_rd_wen = need_dest.
  - spec_rat[in_rd] <= fl_rdata if need_dest.
- Latency 1 cycle. No same-cycle bypass is needed: one rename per cycle.
- Output holds stable while out_valid & !out_ready. out_valid clears when it is consumed and no new accept occurs.
- Commit: if cm_valid & cm_rd_wen & cm_rd!=0, arch_rat[cm_rd] <= cm_prd.
- Release priority:
  - commit release (cm_valid & cm_rd_wen & cm_old_prd!=0) pushes cm_old_prd.
  - Otherwise, sq_valid & sq_prd!=0 pushes sq_prd.
  - sq_ready = !commit_release. A tag of 0 is accepted and dropped.
- Write while fl_full: push suppressed, err_overflow set (cleared only by reset).
- Flush:
  - spec_rat <= arch_rat, including any same-cycle commit write.
  - out_valid <= 0; in_ready=0 that cycle, so no allocation.
  - Commit and squash releases still proceed.
- Reset mid-operation overrides all; no outputs are preserved.

Test Plan:
- Reset, then rename x5 (rs1=x5, rs2=x0) with fl_rdata=1 -> out_prs1=0, out_prd=1, out_old_prd=0, fl_rd_en pulse; next rename of x5 with fl_rdata=2 -> prs1=1, prd=2, old_prd=1.
- fl_empty=1 with in_rd_wen=1 -> in_ready=0, no pop; with in_rd_wen=0 or rd=x0 -> accepted, out_prd=0.
- out_ready=0 for 3 cycles with in_valid=1 -> output held constant, in_ready=0, no pops; release -> exactly one pop per accepted instruction.
- Commit x5 (prd=2, old_prd=1) -> fl_wr_en, fl_wdata=1, arch_rat[5]=2; later flush after renaming x5->3 -> next read of x5 gives 2.
- Same-cycle commit release of 4 and sq_valid with sq_prd=7 -> fl_wdata=4, sq_ready=0; next cycle fl_wdata=7.
- Release with fl_full=1 -> fl_wr_en=0, err_overflow=1 until reset.

Source files
------------

// File: rtl/rename_alloc.sv
// Purpose: single-issue register rename between decode and dispatch, with free-list pop/push.
// Latency: 1 cycle from accept to out_valid; free-list pop and release push are combinational.
// Backpressure: in_ready drops on flush, on a held output (out_valid & !out_ready), or when a dest is needed and the free list is empty.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_*                        decoded instruction (valid/ready), arch sources/dest
//   out_*                       renamed instruction (valid/ready), physical tags
//   fl_*                        physical free-list FIFO (combinational read head)
//   cm_*                        commit of one instruction (updates committed RAT, releases old tag)
//   sq_*                        squashed tag release (valid/ready)
//   flush                       one-cycle recovery pulse: speculative RAT <= committed RAT
//   err_overflow                sticky: a release was attempted while the free list was full
module rename_alloc #(
    parameter int ARCH_REG_NUM   = 32,
    parameter int ARCH_REG_WIDTH = 5,
    parameter int PHY_REG_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    // decode side
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ARCH_REG_WIDTH-1:0] in_rs1,
    input  logic [ARCH_REG_WIDTH-1:0] in_rs2,
    input  logic [ARCH_REG_WIDTH-1:0] in_rd,
    input  logic                      in_rd_wen,
    // dispatch side
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PHY_REG_WIDTH-1:0]  out_prs1,
    output logic [PHY_REG_WIDTH-1:0]  out_prs2,
    output logic [PHY_REG_WIDTH-1:0]  out_prd,
    output logic [PHY_REG_WIDTH-1:0]  out_old_prd,
    output logic                      out_rd_wen,
    // free list
    output logic                      fl_rd_en,
    input  logic [PHY_REG_WIDTH-1:0]  fl_rdata,
    input  logic                      fl_empty,
    output logic                      fl_wr_en,
    output logic [PHY_REG_WIDTH-1:0]  fl_wdata,
    input  logic                      fl_full,
    // commit
    input  logic                      cm_valid,
    input  logic [ARCH_REG_WIDTH-1:0] cm_rd,
    input  logic [PHY_REG_WIDTH-1:0]  cm_prd,
    input  logic [PHY_REG_WIDTH-1:0]  cm_old_prd,
    input  logic                      cm_rd_wen,
    // squash release
    input  logic                      sq_valid,
    input  logic [PHY_REG_WIDTH-1:0]  sq_prd,
    output logic                      sq_ready,
    // recovery / status
    input  logic                      flush,
    output logic                      err_overflow
);

    // Speculative and committed map tables. Entry 0 is never written, so
    // x0 always maps to the hard-wired zero register p0.
    logic [PHY_REG_WIDTH-1:0] r_spec_rat [ARCH_REG_NUM];
    logic [PHY_REG_WIDTH-1:0] r_arch_rat [ARCH_REG_NUM];

    logic                     r_out_valid;
    logic [PHY_REG_WIDTH-1:0] r_out_prs1;
    logic [PHY_REG_WIDTH-1:0] r_out_prs2;
    logic [PHY_REG_WIDTH-1:0] r_out_prd;
    logic [PHY_REG_WIDTH-1:0] r_out_old_prd;
    logic                     r_out_rd_wen;
    logic                     r_err_overflow;

    logic w_need_dest;
    logic w_accept;
    logic w_alloc;
    logic w_commit_wr;
    logic w_commit_rel;
    logic w_squash_rel;
    logic w_release;

    // ------------------------------------------------------------------
    // Rename handshake
    // ------------------------------------------------------------------
    assign w_need_dest = in_rd_wen && (in_rd != '0);
    assign in_ready    = !flush && (!r_out_valid || out_ready) && (!w_need_dest || !fl_empty);
    assign w_accept    = in_valid && in_ready;
    assign w_alloc     = w_accept && w_need_dest;
    assign fl_rd_en    = w_alloc;

    // ------------------------------------------------------------------
    // Commit and release arbitration. Commit release wins; a squash
    // release waits (sq_ready low) while a commit release is present.
    // A squashed tag of 0 is accepted but never pushed, since p0 is
    // not a free-list member.
    // ------------------------------------------------------------------
    assign w_commit_wr  = cm_valid && cm_rd_wen && (cm_rd != '0);
    assign w_commit_rel = cm_valid && cm_rd_wen && (cm_old_prd != '0);
    assign w_squash_rel = !w_commit_rel && sq_valid && (sq_prd != '0);
    assign w_release    = w_commit_rel || w_squash_rel;

    assign sq_ready = !w_commit_rel;
    assign fl_wr_en = w_release && !fl_full;
    assign fl_wdata = w_commit_rel ? cm_old_prd : sq_prd;

    // ------------------------------------------------------------------
    // Committed RAT
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REG_NUM; i++) begin
                r_arch_rat[i] <= '0;
            end
        end else if (w_commit_wr) begin
            r_arch_rat[cm_rd] <= cm_prd;
        end
    end

    // ------------------------------------------------------------------
    // Speculative RAT. On flush the copy must include a commit landing in
    // the same cycle, because r_arch_rat only picks it up at this edge.
    // Flush forces in_ready low, so there is no allocation to merge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REG_NUM; i++) begin
                r_spec_rat[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ARCH_REG_NUM; i++) begin
                r_spec_rat[i] <= (w_commit_wr && (cm_rd == ARCH_REG_WIDTH'(i))) ? cm_prd : r_arch_rat[i];
            end
        end else if (w_alloc) begin
            r_spec_rat[in_rd] <= fl_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Output register. The payload only changes on accept, so it stays
    // stable while the downstream stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_prs1    <= '0;
            r_out_prs2    <= '0;
            r_out_prd     <= '0;
            r_out_old_prd <= '0;
            r_out_rd_wen  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_prs1    <= r_spec_rat[in_rs1];
                r_out_prs2    <= r_spec_rat[in_rs2];
                r_out_prd     <= w_need_dest ? fl_rdata : '0;
                r_out_old_prd <= w_need_dest ? r_spec_rat[in_rd] : '0;
                r_out_rd_wen  <= w_need_dest;
            end else if (flush || out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow flag: a release that had to be dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_overflow <= 1'b0;
        end else if (w_release && fl_full) begin
            r_err_overflow <= 1'b1;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_prs1     = r_out_prs1;
    assign out_prs2     = r_out_prs2;
    assign out_prd      = r_out_prd;
    assign out_old_prd  = r_out_old_prd;
    assign out_rd_wen   = r_out_rd_wen;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_rename_alloc.sv
// Purpose: self-checking bench for rename_alloc with an expected-output queue.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1-2ns after or on the falling edge.
// Backpressure: out_ready is driven per scenario, including random stalls.
module tb_rename_alloc;

    typedef struct packed {
        logic [5:0] prs1;
        logic [5:0] prs2;
        logic [5:0] prd;
        logic [5:0] old_prd;
        logic       rd_wen;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_rs1, in_rs2, in_rd;
    logic       in_rd_wen;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_prs1, out_prs2, out_prd, out_old_prd;
    logic       out_rd_wen;
    logic       fl_rd_en;
    logic [5:0] fl_rdata;
    logic       fl_empty;
    logic       fl_wr_en;
    logic [5:0] fl_wdata;
    logic       fl_full;
    logic       cm_valid;
    logic [4:0] cm_rd;
    logic [5:0] cm_prd, cm_old_prd;
    logic       cm_rd_wen;
    logic       sq_valid;
    logic [5:0] sq_prd;
    logic       sq_ready;
    logic       flush;
    logic       err_overflow;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [5:0] m_spec [32];
    logic [5:0] m_arch [32];

    always #5 clk = ~clk;

    rename_alloc dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
        .out_old_prd(out_old_prd), .out_rd_wen(out_rd_wen),
        .fl_rd_en(fl_rd_en), .fl_rdata(fl_rdata), .fl_empty(fl_empty),
        .fl_wr_en(fl_wr_en), .fl_wdata(fl_wdata), .fl_full(fl_full),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_prd(cm_prd),
        .cm_old_prd(cm_old_prd), .cm_rd_wen(cm_rd_wen),
        .sq_valid(sq_valid), .sq_prd(sq_prd), .sq_ready(sq_ready),
        .flush(flush), .err_overflow(err_overflow)
    );

    // Output monitor: every handshake pops one expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: got prd=%0d, expected no output", out_prd);
            end else begin
                mon_e = sb.pop_front();
                if ({out_prs1, out_prs2, out_prd, out_old_prd, out_rd_wen} !== mon_e) begin
                    n_bad++;
                    $display("FAIL sb_payload: got prs1=%0d prs2=%0d prd=%0d old=%0d wen=%0b, expected prs1=%0d prs2=%0d prd=%0d old=%0d wen=%0b",
                             out_prs1, out_prs2, out_prd, out_old_prd, out_rd_wen,
                             mon_e.prs1, mon_e.prs2, mon_e.prd, mon_e.old_prd, mon_e.rd_wen);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_wen = 1'b0;
        out_ready  = 1'b1;
        fl_rdata   = '0; fl_empty = 1'b0; fl_full = 1'b0;
        cm_valid   = 1'b0; cm_rd = '0; cm_prd = '0; cm_old_prd = '0; cm_rd_wen = 1'b0;
        sq_valid   = 1'b0; sq_prd = '0;
        flush      = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_spec[i] = '0;
            m_arch[i] = '0;
        end
    endtask

    task automatic drive_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic wen, input logic [5:0] tag);
        in_valid  = 1'b1;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_rd_wen = wen;
        fl_rdata  = tag;
    endtask

    // Expected output of an instruction the bench knows is being accepted.
    task automatic push_rename(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic wen, input logic [5:0] tag);
        exp_t e;
        logic need;
        need      = wen && (rd != 5'd0);
        e.prs1    = m_spec[rs1];
        e.prs2    = m_spec[rs2];
        e.prd     = need ? tag : 6'd0;
        e.old_prd = need ? m_spec[rd] : 6'd0;
        e.rd_wen  = need;
        sb.push_back(e);
        if (need) m_spec[rd] = tag;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_valid = 1'b1; in_rd = 5'd3; in_rd_wen = 1'b1; fl_rdata = 6'd9;
        reset = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
        n_cmp++; if ({out_prs1, out_prs2, out_prd, out_old_prd, out_rd_wen} !== 25'd0) begin n_bad++; $display("FAIL reset_payload: got prd=%0d old=%0d, expected 0", out_prd, out_old_prd); end
        n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b, expected 0", err_overflow); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
        n_cmp++; if (fl_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_fl_wr_en: got %0b, expected 0", fl_wr_en); end
        reset = 1'b0;
        model_reset();
        cyc();
    endtask

    task automatic test_basic_rename();
        drive_in(5'd5, 5'd0, 5'd5, 1'b1, 6'd1);
        #1;
        n_cmp++; if (in_ready !== 1'b1 || fl_rd_en !== 1'b1) begin n_bad++; $display("FAIL basic_pop1: got rdy=%0b pop=%0b, expected 1/1", in_ready, fl_rd_en); end
        push_rename(5'd5, 5'd0, 5'd5, 1'b1, 6'd1);
        cyc();
        n_cmp++; if (out_valid !== 1'b1 || out_prs1 !== 6'd0 || out_prd !== 6'd1 || out_old_prd !== 6'd0) begin
            n_bad++; $display("FAIL basic_first: got v=%0b prs1=%0d prd=%0d old=%0d, expected 1/0/1/0", out_valid, out_prs1, out_prd, out_old_prd); end
        drive_in(5'd5, 5'd0, 5'd5, 1'b1, 6'd2);
        #1;
        n_cmp++; if (in_ready !== 1'b1 || fl_rd_en !== 1'b1) begin n_bad++; $display("FAIL basic_pop2: got rdy=%0b pop=%0b, expected 1/1", in_ready, fl_rd_en); end
        push_rename(5'd5, 5'd0, 5'd5, 1'b1, 6'd2);
        cyc();
        in_valid = 1'b0;
        n_cmp++; if (out_prs1 !== 6'd1 || out_prd !== 6'd2 || out_old_prd !== 6'd1 || out_rd_wen !== 1'b1) begin
            n_bad++; $display("FAIL basic_second: got prs1=%0d prd=%0d old=%0d wen=%0b, expected 1/2/1/1", out_prs1, out_prd, out_old_prd, out_rd_wen); end
        #1;
        n_cmp++; if (fl_rd_en !== 1'b0) begin n_bad++; $display("FAIL basic_nopop: got %0b, expected 0", fl_rd_en); end
        cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain: got out_valid=%0b, expected 0", out_valid); end
    endtask

    task automatic test_free_list_empty();
        drive_in(5'd1, 5'd2, 5'd7, 1'b1, 6'd3);
        fl_empty = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0 || fl_rd_en !== 1'b0) begin n_bad++; $display("FAIL empty_stall: got rdy=%0b pop=%0b, expected 0/0", in_ready, fl_rd_en); end
        cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL empty_no_out: got %0b, expected 0", out_valid); end
        in_rd_wen = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || fl_rd_en !== 1'b0) begin n_bad++; $display("FAIL empty_nowen: got rdy=%0b pop=%0b, expected 1/0", in_ready, fl_rd_en); end
        push_rename(5'd1, 5'd2, 5'd7, 1'b0, 6'd3);
        cyc();
        n_cmp++; if (out_valid !== 1'b1 || out_prd !== 6'd0 || out_rd_wen !== 1'b0) begin n_bad++; $display("FAIL empty_nowen_out: got v=%0b prd=%0d wen=%0b, expected 1/0/0", out_valid, out_prd, out_rd_wen); end
        in_rd = 5'd0; in_rd_wen = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || fl_rd_en !== 1'b0) begin n_bad++; $display("FAIL empty_x0: got rdy=%0b pop=%0b, expected 1/0", in_ready, fl_rd_en); end
        push_rename(5'd1, 5'd2, 5'd0, 1'b1, 6'd3);
        cyc();
        n_cmp++; if (out_prd !== 6'd0 || out_old_prd !== 6'd0) begin n_bad++; $display("FAIL empty_x0_out: got prd=%0d old=%0d, expected 0/0", out_prd, out_old_prd); end
        in_valid = 1'b0; fl_empty = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        int pops;
        pops = 0;
        drive_in(5'd5, 5'd5, 5'd6, 1'b1, 6'd3);
        #1;
        if (fl_rd_en === 1'b1) pops++;
        push_rename(5'd5, 5'd5, 5'd6, 1'b1, 6'd3);
        cyc();
        out_ready = 1'b0;
        drive_in(5'd6, 5'd0, 5'd7, 1'b1, 6'd4);
        for (int k = 0; k < 3; k++) begin
            #1;
            if (fl_rd_en === 1'b1) pops++;
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_prd !== 6'd3 || out_prs1 !== 6'd2) begin
                n_bad++; $display("FAIL bp_hold%0d: got rdy=%0b v=%0b prd=%0d prs1=%0d, expected 0/1/3/2", k, in_ready, out_valid, out_prd, out_prs1); end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        if (fl_rd_en === 1'b1) pops++;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got rdy=%0b, expected 1", in_ready); end
        push_rename(5'd6, 5'd0, 5'd7, 1'b1, 6'd4);
        cyc();
        in_valid = 1'b0;
        #1;
        if (fl_rd_en === 1'b1) pops++;
        n_cmp++; if (pops !== 2) begin n_bad++; $display("FAIL bp_pops: got %0d pops, expected 2", pops); end
        n_cmp++; if (out_prd !== 6'd4 || out_prs1 !== 6'd3) begin n_bad++; $display("FAIL bp_second: got prd=%0d prs1=%0d, expected 4/3", out_prd, out_prs1); end
        cyc();
    endtask

    task automatic test_commit_flush();
        cm_valid = 1'b1; cm_rd = 5'd5; cm_prd = 6'd2; cm_old_prd = 6'd1; cm_rd_wen = 1'b1;
        #1;
        n_cmp++; if (fl_wr_en !== 1'b1 || fl_wdata !== 6'd1) begin n_bad++; $display("FAIL commit_release: got wr=%0b data=%0d, expected 1/1", fl_wr_en, fl_wdata); end
        m_arch[5] = 6'd2;
        cyc();
        cm_valid = 1'b0;
        drive_in(5'd5, 5'd0, 5'd5, 1'b1, 6'd3);
        #1;
        push_rename(5'd5, 5'd0, 5'd5, 1'b1, 6'd3);
        cyc();
        in_valid = 1'b0;
        n_cmp++; if (out_prd !== 6'd3 || out_old_prd !== 6'd2) begin n_bad++; $display("FAIL commit_spec: got prd=%0d old=%0d, expected 3/2", out_prd, out_old_prd); end
        cyc();
        // Flush with a same-cycle commit of x8 and an instruction offered.
        flush = 1'b1;
        cm_valid = 1'b1; cm_rd = 5'd8; cm_prd = 6'd9; cm_old_prd = 6'd0; cm_rd_wen = 1'b1;
        drive_in(5'd9, 5'd0, 5'd9, 1'b1, 6'd10);
        #1;
        n_cmp++; if (in_ready !== 1'b0 || fl_rd_en !== 1'b0 || fl_wr_en !== 1'b0) begin
            n_bad++; $display("FAIL flush_block: got rdy=%0b pop=%0b wr=%0b, expected 0/0/0", in_ready, fl_rd_en, fl_wr_en); end
        m_arch[8] = 6'd9;
        for (int i = 0; i < 32; i++) m_spec[i] = m_arch[i];
        cyc();
        flush = 1'b0; cm_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %0b, expected 0", out_valid); end
        drive_in(5'd5, 5'd8, 5'd0, 1'b0, 6'd0);
        #1;
        push_rename(5'd5, 5'd8, 5'd0, 1'b0, 6'd0);
        cyc();
        in_valid = 1'b0;
        n_cmp++; if (out_prs1 !== 6'd2 || out_prs2 !== 6'd9) begin n_bad++; $display("FAIL flush_recover: got prs1=%0d prs2=%0d, expected 2/9", out_prs1, out_prs2); end
        cyc();
    endtask

    task automatic test_release_priority();
        cm_valid = 1'b1; cm_rd = 5'd3; cm_prd = 6'd5; cm_old_prd = 6'd4; cm_rd_wen = 1'b1;
        sq_valid = 1'b1; sq_prd = 6'd7;
        #1;
        n_cmp++; if (fl_wr_en !== 1'b1 || fl_wdata !== 6'd4 || sq_ready !== 1'b0) begin
            n_bad++; $display("FAIL prio_commit: got wr=%0b data=%0d sq_rdy=%0b, expected 1/4/0", fl_wr_en, fl_wdata, sq_ready); end
        m_arch[3] = 6'd5;
        cyc();
        cm_valid = 1'b0;
        #1;
        n_cmp++; if (fl_wr_en !== 1'b1 || fl_wdata !== 6'd7 || sq_ready !== 1'b1) begin
            n_bad++; $display("FAIL prio_squash: got wr=%0b data=%0d sq_rdy=%0b, expected 1/7/1", fl_wr_en, fl_wdata, sq_ready); end
        cyc();
        sq_prd = 6'd0;
        #1;
        n_cmp++; if (fl_wr_en !== 1'b0 || sq_ready !== 1'b1) begin n_bad++; $display("FAIL prio_sq_zero: got wr=%0b sq_rdy=%0b, expected 0/1", fl_wr_en, sq_ready); end
        cyc();
        sq_valid = 1'b0;
        cm_valid = 1'b1; cm_rd = 5'd4; cm_prd = 6'd11; cm_old_prd = 6'd12; cm_rd_wen = 1'b0;
        #1;
        n_cmp++; if (fl_wr_en !== 1'b0 || sq_ready !== 1'b1) begin n_bad++; $display("FAIL prio_nowen: got wr=%0b sq_rdy=%0b, expected 0/1", fl_wr_en, sq_ready); end
        cyc();
        cm_valid = 1'b0;
    endtask

    task automatic test_overflow();
        n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_pre: got %0b, expected 0", err_overflow); end
        fl_full = 1'b1; sq_valid = 1'b1; sq_prd = 6'd9;
        #1;
        n_cmp++; if (fl_wr_en !== 1'b0) begin n_bad++; $display("FAIL ovf_suppress: got wr=%0b, expected 0", fl_wr_en); end
        cyc();
        sq_valid = 1'b0; fl_full = 1'b0;
        n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b, expected 1", err_overflow); end
        cyc();
        cyc();
        n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0b, expected 1", err_overflow); end
        // Leave an output pending, then reset over it.
        out_ready = 1'b0;
        drive_in(5'd2, 5'd0, 5'd2, 1'b1, 6'd20);
        cyc();
        in_valid = 1'b0;
        reset = 1'b1;
        cyc();
        n_cmp++; if (out_valid !== 1'b0 || out_prd !== 6'd0 || err_overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_reset: got v=%0b prd=%0d err=%0b, expected 0/0/0", out_valid, out_prd, err_overflow); end
        reset = 1'b0; out_ready = 1'b1;
        model_reset();
        drive_in(5'd5, 5'd2, 5'd0, 1'b0, 6'd0);
        #1;
        push_rename(5'd5, 5'd2, 5'd0, 1'b0, 6'd0);
        cyc();
        in_valid = 1'b0;
        n_cmp++; if (out_prs1 !== 6'd0 || out_prs2 !== 6'd0) begin n_bad++; $display("FAIL ovf_rat_cleared: got prs1=%0d prs2=%0d, expected 0/0", out_prs1, out_prs2); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic tb_ov;
        logic need;
        logic exp_rdy;
        logic [4:0] rs1, rs2, rd;
        logic wen;
        logic [5:0] tag;
        tb_ov = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            wen = 1'($urandom_range(0, 3) != 0);
            tag = 6'($urandom_range(1, 32));
            drive_in(rs1, rs2, rd, wen, tag);
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            fl_empty  = 1'($urandom_range(0, 5) == 0);
            #1;
            need    = wen && (rd != 5'd0);
            exp_rdy = (!tb_ov || out_ready) && !(need && fl_empty);
            n_cmp++; if (in_ready !== exp_rdy || fl_rd_en !== (in_valid && exp_rdy && need)) begin
                n_bad++; $display("FAIL b2b_hs%0d: got rdy=%0b pop=%0b, expected %0b/%0b", k, in_ready, fl_rd_en, exp_rdy, in_valid && exp_rdy && need); end
            if (in_valid && exp_rdy) begin
                push_rename(rs1, rs2, rd, wen, tag);
                tb_ov = 1'b1;
            end else if (out_ready) begin
                tb_ov = 1'b0;
            end
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1; fl_empty = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d outstanding, expected 0", sb.size()); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        test_reset();
        test_basic_rename();
        test_free_list_empty();
        test_backpressure();
        test_commit_flush();
        test_release_priority();
        test_overflow();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
